// File: rtl/hvac_zone_controller_pkg.sv
// Shared definitions for the multi-zone HVAC controller.
// Contents: per-zone state encoding and the sensor-fault code check.
// No ports (package).
package hvac_zone_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAT = 2'd1,
        ST_COOL = 2'd2
    } zone_state_e;

    // A sensor reporting the all-ones code for its width is treated as broken.
    function automatic logic is_fault_code(input logic [31:0] temp, input int unsigned temp_w);
        return temp == ((32'd1 << temp_w) - 32'd1);
    endfunction

endpackage

// File: rtl/hvac_zone_controller_if.sv
// Zone sensor / actuator bundle for the HVAC controller.
// master: sensor/supervisor side, drives enable, temperature, temp_valid,
//         initial_heating, initial_cooling; observes heating, cooling, sensor_fault.
// slave:  controller side, the reverse.
interface hvac_zone_controller_if #(
    parameter int N_ZONES = 4,
    parameter int TEMP_W  = 5
);
    logic                        enable;
    logic [N_ZONES*TEMP_W-1:0]   temperature;
    logic [N_ZONES-1:0]          temp_valid;
    logic [N_ZONES-1:0]          initial_heating;
    logic [N_ZONES-1:0]          initial_cooling;
    logic [N_ZONES-1:0]          heating;
    logic [N_ZONES-1:0]          cooling;
    logic [N_ZONES-1:0]          sensor_fault;

    modport master (
        output enable, temperature, temp_valid, initial_heating, initial_cooling,
        input  heating, cooling, sensor_fault
    );

    modport slave (
        input  enable, temperature, temp_valid, initial_heating, initial_cooling,
        output heating, cooling, sensor_fault
    );
endinterface

// File: rtl/hvac_zone_controller_zone_fsm.sv
// One HVAC zone: IDLE/HEATING/COOLING state machine with hysteresis,
// minimum-dwell counter and sticky sensor-fault flag.
// Ports: clk, rst (sync, active-high), enable, temp, valid, init_heat,
//        init_cool (sampled during rst); heating, cooling, sensor_fault (registered).
module hvac_zone_fsm
    import hvac_zone_controller_pkg::*;
#(
    parameter int TEMP_W    = 5,
    parameter int HEAT_ON   = 18,
    parameter int HEAT_OFF  = 20,
    parameter int COOL_ON   = 22,
    parameter int COOL_OFF  = 20,
    parameter int MIN_DWELL = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [TEMP_W-1:0] temp,
    input  logic              valid,
    input  logic              init_heat,
    input  logic              init_cool,
    output logic              heating,
    output logic              cooling,
    output logic              sensor_fault
);
    localparam int DW = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;
    localparam logic [DW-1:0]     DWELL_MAX = DW'(MIN_DWELL);
    localparam logic [TEMP_W-1:0] T_HEAT_ON  = TEMP_W'(HEAT_ON);
    localparam logic [TEMP_W-1:0] T_HEAT_OFF = TEMP_W'(HEAT_OFF);
    localparam logic [TEMP_W-1:0] T_COOL_ON  = TEMP_W'(COOL_ON);
    localparam logic [TEMP_W-1:0] T_COOL_OFF = TEMP_W'(COOL_OFF);

    zone_state_e   state;
    zone_state_e   state_nxt;
    logic [DW-1:0] dwell;
    logic          dwell_met;
    logic          fault_hit;

    // With no dwell requirement the counter is kept but never gates an exit.
    if (MIN_DWELL == 0) begin : g_no_dwell
        assign dwell_met = 1'b1;
    end else begin : g_dwell
        assign dwell_met = (dwell >= DWELL_MAX);
    end

    always_comb begin
        fault_hit = valid && is_fault_code(32'(temp), TEMP_W);
        state_nxt = state;
        // Disable, an existing fault or a fresh fault code all force IDLE regardless of dwell.
        if (!enable || sensor_fault || fault_hit) begin
            state_nxt = ST_IDLE;
        end else if (valid && dwell_met) begin
            case (state)
                ST_IDLE: begin
                    if (temp <= T_HEAT_ON)      state_nxt = ST_HEAT;
                    else if (temp >= T_COOL_ON) state_nxt = ST_COOL;
                end
                ST_HEAT: if (temp >= T_HEAT_OFF) state_nxt = ST_IDLE;
                ST_COOL: if (temp <= T_COOL_OFF) state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Conflicting or absent init requests start the zone IDLE.
            if (init_heat && !init_cool)      state <= ST_HEAT;
            else if (init_cool && !init_heat) state <= ST_COOL;
            else                              state <= ST_IDLE;
            heating      <= init_heat && !init_cool;
            cooling      <= init_cool && !init_heat;
            dwell        <= '0;
            sensor_fault <= 1'b0;
        end else begin
            state   <= state_nxt;
            heating <= (state_nxt == ST_HEAT);
            cooling <= (state_nxt == ST_COOL);
            // Faults are only latched while enabled; once set only rst clears them.
            if (enable && fault_hit) sensor_fault <= 1'b1;
            if (!enable || (state_nxt != state)) dwell <= '0;
            else if (dwell != DWELL_MAX)         dwell <= dwell + 1'b1;
        end
    end
endmodule

// File: rtl/hvac_zone_controller.sv
// Multi-zone HVAC controller top: slices the zone buses, checks the
// threshold parameters and instantiates one hvac_zone_fsm per zone.
// Ports: clk, rst (sync, active-high), bus (hvac_zone_controller_if.slave).
module hvac_zone_controller
    import hvac_zone_controller_pkg::*;
#(
    parameter int N_ZONES   = 4,
    parameter int TEMP_W    = 5,
    parameter int HEAT_ON   = 18,
    parameter int HEAT_OFF  = 20,
    parameter int COOL_ON   = 22,
    parameter int COOL_OFF  = 20,
    parameter int MIN_DWELL = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    hvac_zone_controller_if.slave  bus
);
    localparam int T_MAX = (1 << TEMP_W) - 1;
    localparam bit PARAMS_OK = (N_ZONES >= 1) && (HEAT_ON < HEAT_OFF) && (HEAT_OFF <= COOL_ON)
                            && (COOL_OFF < COOL_ON) && (HEAT_ON < T_MAX) && (HEAT_OFF < T_MAX)
                            && (COOL_ON < T_MAX) && (COOL_OFF < T_MAX) && (MIN_DWELL >= 0);

    if (!PARAMS_OK) begin : g_param_err
        $error("hvac_zone_controller: illegal threshold/zone parameters");
    end

    logic [N_ZONES-1:0] heat_v;
    logic [N_ZONES-1:0] cool_v;
    logic [N_ZONES-1:0] fault_v;

    for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
        hvac_zone_fsm #(
            .TEMP_W   (TEMP_W),
            .HEAT_ON  (HEAT_ON),
            .HEAT_OFF (HEAT_OFF),
            .COOL_ON  (COOL_ON),
            .COOL_OFF (COOL_OFF),
            .MIN_DWELL(MIN_DWELL)
        ) u_zone (
            .clk         (clk),
            .rst         (rst),
            .enable      (bus.enable),
            .temp        (bus.temperature[z*TEMP_W +: TEMP_W]),
            .valid       (bus.temp_valid[z]),
            .init_heat   (bus.initial_heating[z]),
            .init_cool   (bus.initial_cooling[z]),
            .heating     (heat_v[z]),
            .cooling     (cool_v[z]),
            .sensor_fault(fault_v[z])
        );
    end

    assign bus.heating      = heat_v;
    assign bus.cooling      = cool_v;
    assign bus.sensor_fault = fault_v;
endmodule
